// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state encoding and round-robin pick for the SPI transaction scheduler
package spi_sched_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_HOLD,
        ST_DONE
    } state_t;

    // First asserted request at or after ptr, wrapping within the low n bits.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [2:0] idx;
        logic       found;
        int         c;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                c = (int'(ptr) + k) % n;
                if (!found && req[c]) begin
                    found = 1'b1;
                    idx   = c[2:0];
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin arbiter returning one-hot grant and index
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_REQ-1:0] req_pad;
    logic [2:0]         pick;

    always_comb begin
        req_pad           = '0;
        req_pad[NREQ-1:0] = req;
    end

    assign pick = rr_pick(req_pad, 3'(ptr), NREQ);
    assign any  = |req;
    assign idx  = pick[IDX_W-1:0];
    assign gnt  = any ? (NREQ'(1) << pick) : '0;

endmodule

// File: rtl/spi_txn_scheduler.sv
// rtl/spi_txn_scheduler.sv - round-robin multi-byte transaction scheduler in front of one spi_master
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int LEN_W    = 8,
    parameter int GAP_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TMO_W    = 12
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  spe_in,
    input  logic [GAP_W-1:0]      gap_in,
    input  logic [NREQ-1:0]       req_in,
    input  logic [NREQ*LEN_W-1:0] len_in,
    output logic [NREQ-1:0]       gnt_out,
    output logic [LEN_W-1:0]      byte_idx_out,
    output logic [NREQ-1:0]       done_out,
    output logic                  err_out,
    output logic                  new_tx_out,
    input  logic                  finished_in,
    output logic [NREQ-1:0]       ss_n_out,
    output logic                  busy_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (GAP_W > 8) ? GAP_W : 8;
    // Timeout fires on the WAIT cycle where the watchdog would become all-ones.
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam state_t ST_AFTER_REQ  = (CS_SETUP == 0) ? ST_ISSUE : ST_SETUP;
    localparam state_t ST_AFTER_LAST = (CS_HOLD == 0) ? ST_DONE : ST_HOLD;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt, win, win_nxt, win_inc, arb_idx;
    logic [NREQ-1:0]    arb_gnt;
    logic               arb_any;
    logic [LEN_W-1:0]   remain, remain_nxt, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_len, gap_len_nxt;
    logic [TMO_W-1:0]   wd, wd_nxt;
    logic [NREQ-1:0]    gnt_nxt, ss_n_nxt, done_nxt;
    logic               err_nxt, new_tx_nxt, busy_nxt;

    spi_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req_in),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign win_inc = (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            win          <= '0;
            remain       <= '0;
            cnt          <= '0;
            gap_len      <= '0;
            wd           <= '0;
            gnt_out      <= '0;
            ss_n_out     <= '1;
            done_out     <= '0;
            err_out      <= 1'b0;
            new_tx_out   <= 1'b0;
            busy_out     <= 1'b0;
            byte_idx_out <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            win          <= win_nxt;
            remain       <= remain_nxt;
            cnt          <= cnt_nxt;
            gap_len      <= gap_len_nxt;
            wd           <= wd_nxt;
            gnt_out      <= gnt_nxt;
            ss_n_out     <= ss_n_nxt;
            done_out     <= done_nxt;
            err_out      <= err_nxt;
            new_tx_out   <= new_tx_nxt;
            busy_out     <= busy_nxt;
            byte_idx_out <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        win_nxt     = win;
        remain_nxt  = remain;
        idx_nxt     = byte_idx_out;
        cnt_nxt     = cnt;
        gap_len_nxt = gap_len;
        wd_nxt      = wd;
        gnt_nxt     = gnt_out;
        ss_n_nxt    = ss_n_out;
        done_nxt    = '0;
        err_nxt     = 1'b0;
        new_tx_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (spe_in && arb_any) begin
                    win_nxt    = arb_idx;
                    remain_nxt = len_in[arb_idx*LEN_W +: LEN_W];
                    gnt_nxt    = arb_gnt;
                    ss_n_nxt   = ~arb_gnt;
                    idx_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_AFTER_REQ;
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_W'(CS_SETUP - 1)) state_nxt = ST_ISSUE;
                else                            cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_ISSUE: begin
                new_tx_nxt = 1'b1;
                wd_nxt     = '0;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish arriving on the timeout cycle takes priority.
                if (finished_in) begin
                    if (remain == '0) begin
                        state_nxt = ST_AFTER_LAST;
                        cnt_nxt   = '0;
                    end else begin
                        remain_nxt = remain - LEN_W'(1);
                        idx_nxt    = byte_idx_out + LEN_W'(1);
                        if (gap_in != '0) begin
                            gap_len_nxt = gap_in;
                            cnt_nxt     = '0;
                            state_nxt   = ST_GAP;
                        end else begin
                            state_nxt   = ST_ISSUE;
                        end
                    end
                end else if (wd == WD_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_AFTER_LAST;
                end else begin
                    wd_nxt = wd + TMO_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(gap_len) - CNT_W'(1)) state_nxt = ST_ISSUE;
                else                                   cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_HOLD: begin
                if (cnt == CNT_W'(CS_HOLD - 1)) state_nxt = ST_DONE;
                else                           cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_DONE: begin
                done_nxt  = gnt_out;
                gnt_nxt   = '0;
                ss_n_nxt  = '1;
                ptr_nxt   = win_inc;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Losing enable aborts the transaction without a done; the pointer still moves on.
        if (state != ST_IDLE && !spe_in) begin
            state_nxt  = ST_IDLE;
            gnt_nxt    = '0;
            ss_n_nxt   = '1;
            done_nxt   = '0;
            new_tx_nxt = 1'b0;
            err_nxt    = 1'b1;
            ptr_nxt    = win_inc;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
